// File: rtl/speech256_pkg.sv
// Shared definitions for the speech256 allophone path: code width,
// pause allophone codes and a constant-foldable ceiling log2.
package speech256_pkg;

    localparam int ALLO_W = 6;

    localparam logic [ALLO_W-1:0] PA1 = 6'd0;
    localparam logic [ALLO_W-1:0] PA2 = 6'd1;
    localparam logic [ALLO_W-1:0] PA3 = 6'd2;
    localparam logic [ALLO_W-1:0] PA4 = 6'd3;
    localparam logic [ALLO_W-1:0] PA5 = 6'd4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/allophone_fifo_if.sv
// Host strobe side plus sequencer side of the allophone queue, as one bundle.
interface allophone_fifo_if
    import speech256_pkg::*;
#(
    parameter int DATA_W = ALLO_W,
    parameter int DEPTH  = 8
);
    localparam int LVL_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_in;
    logic              data_stb;
    logic              ldq;
    logic              flush;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic              low_water;
    logic              overflow;

    modport slave (
        input  data_in, data_stb, flush, out_ready,
        output ldq, out_data, out_valid, level, low_water, overflow
    );

    modport master (
        output data_in, data_stb, flush, out_ready,
        input  ldq, out_data, out_valid, level, low_water, overflow
    );

endinterface

// File: rtl/allophone_fifo_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
module allophone_fifo_mem #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/allophone_fifo.sv
// First-word-fall-through allophone queue between the host strobe port and
// the speech sequencer, with level, low-water, sticky overflow and flush.
module allophone_fifo
    import speech256_pkg::*;
#(
    parameter int DATA_W   = ALLO_W,
    parameter int DEPTH    = 8,
    parameter int LOW_TH   = 2,
    parameter int STB_EDGE = 1
) (
    input  logic            clk,
    input  logic            rst_an,
    allophone_fifo_if.slave bus
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_TH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic             r_stb_d;

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_overflow_nxt;
    logic             w_push_req;
    logic             w_ldq;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_reject;

    assign w_push_req  = (STB_EDGE != 0) ? (bus.data_stb & ~r_stb_d) : bus.data_stb;
    assign w_ldq       = (r_level != FULL_LVL);
    assign w_out_valid = (r_level != {LVL_W{1'b0}});

    // Flush wins over everything, including a strobe landing in the same cycle.
    assign w_push   = w_push_req &  w_ldq & ~bus.flush;
    assign w_reject = w_push_req & ~w_ldq & ~bus.flush;
    assign w_pop    = w_out_valid & bus.out_ready & ~bus.flush;

    // next-state for pointers, level and overflow
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_level_nxt    = r_level;
        w_overflow_nxt = r_overflow;
        if (bus.flush) begin
            w_wr_ptr_nxt   = {PTR_W{1'b0}};
            w_rd_ptr_nxt   = {PTR_W{1'b0}};
            w_level_nxt    = {LVL_W{1'b0}};
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_ONE;
                2'b01:   w_level_nxt = r_level - LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
            if (w_reject) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_overflow_nxt = r_overflow;
            end
        end
    end

    // state registers; stb_d resets high so a strobe held through reset is not an edge
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_level    <= {LVL_W{1'b0}};
            r_overflow <= 1'b0;
            r_stb_d    <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_level    <= w_level_nxt;
            r_overflow <= w_overflow_nxt;
            r_stb_d    <= bus.data_stb;
        end
    end

    allophone_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (bus.out_data)
    );

    assign bus.ldq       = w_ldq;
    assign bus.out_valid = w_out_valid;
    assign bus.level     = r_level;
    assign bus.low_water = (r_level <= LOW_LVL);
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_allophone_fifo.sv
// Directed vector bench for allophone_fifo: edge-strobe instance driven from a
// table, level-strobe instance and asynchronous reset checked by hand.
module tb_allophone_fifo;
    import speech256_pkg::*;

    localparam int DW = 6;
    localparam int DP = 8;
    localparam int LW = clog2(DP + 1);

    logic clk = 1'b0;
    logic rst_an = 1'b0;
    always #5 clk = ~clk;

    allophone_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus_a ();
    allophone_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus_b ();

    allophone_fifo #(.DATA_W(DW), .DEPTH(DP), .LOW_TH(2), .STB_EDGE(1)) dut_a (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus_a.slave)
    );

    allophone_fifo #(.DATA_W(DW), .DEPTH(DP), .LOW_TH(2), .STB_EDGE(0)) dut_b (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus_b.slave)
    );

    typedef struct packed {
        logic          stb;
        logic [DW-1:0] din;
        logic          rdy;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic [LW-1:0] el;
        logic          eldq;
        logic          elow;
        logic          eovf;
    } vec_t;

    vec_t vecs[$];
    int n_vec = 0;
    int n_err = 0;
    int rej = 0;

    // ldq/low_water follow directly from the expected level (DEPTH 8, LOW_TH 2)
    function automatic void add(input logic stb, input int din, input logic rdy, input logic fl,
                                input logic ev, input int ed, input int el, input logic eovf);
        vec_t v;
        v.stb  = stb;
        v.din  = DW'(din);
        v.rdy  = rdy;
        v.fl   = fl;
        v.ev   = ev;
        v.ed   = DW'(ed);
        v.el   = LW'(el);
        v.eldq = (el != 8);
        v.elow = (el <= 2);
        v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        bus_a.data_in = '0; bus_a.data_stb = 1'b0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.data_in = '0; bus_b.data_stb = 1'b0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b0;

        // first three codes, then drain
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 6, 0, 0, 1, 6, 1, 0);
        add(0, 0, 0, 0, 1, 6, 1, 0);
        add(1, 12, 0, 0, 1, 6, 2, 0);
        add(0, 0, 0, 0, 1, 6, 2, 0);
        add(1, 63, 0, 0, 1, 6, 3, 0);
        add(0, 0, 0, 0, 1, 6, 3, 0);
        add(0, 0, 1, 0, 1, 12, 2, 0);
        add(0, 0, 1, 0, 1, 63, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // fill to DEPTH, then a rejected 9th
        for (int i = 0; i < 8; i++) begin
            add(1, 10 + i, 0, 0, 1, 10, i + 1, 0);
            add(0, 0, 0, 0, 1, 10, i + 1, 0);
        end
        add(1, 50, 0, 0, 1, 10, 8, 1);
        add(0, 0, 0, 0, 1, 10, 8, 1);
        // full: strobe and pop together
        add(1, 51, 1, 0, 1, 11, 7, 1);
        add(0, 0, 0, 0, 1, 11, 7, 1);
        for (int k = 1; k <= 7; k++) begin
            add(0, 0, 1, 0, (k < 7), (k < 7) ? 11 + k : 0, 7 - k, 1);
        end
        // five entries with overflow set, then flush with a strobe
        for (int i = 0; i < 5; i++) begin
            add(1, 30 + i, 0, 0, 1, 30, i + 1, 1);
            add(0, 0, 0, 0, 1, 30, i + 1, 1);
        end
        add(1, 33, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // strobe held ten cycles: one push only
        for (int c = 0; c < 10; c++) begin
            add(1, 40, 0, 0, 1, 40, 1, 0);
        end
        add(0, 0, 0, 0, 1, 40, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // twenty push/pop pairs, pointers wrap twice
        for (int p = 0; p < 20; p++) begin
            add(1, (p * 3 + 1) % 64, 1, 0, 1, (p * 3 + 1) % 64, 1, 0);
            add(0, 0, 1, 0, 0, 0, 0, 0);
        end

        #12;
        check("reset_a", {27'd0, bus_a.out_valid, bus_a.level, bus_a.ldq, bus_a.low_water, bus_a.overflow},
              {27'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
        check("reset_b", {27'd0, bus_b.out_valid, bus_b.level, bus_b.ldq, bus_b.low_water, bus_b.overflow},
              {27'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        rst_an = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus_a.data_stb  = vecs[i].stb;
            bus_a.data_in   = vecs[i].din;
            bus_a.out_ready = vecs[i].rdy;
            bus_a.flush     = vecs[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {18'd0, bus_a.out_valid, (vecs[i].ev ? bus_a.out_data : 6'd0), bus_a.level,
                   bus_a.ldq, bus_a.low_water, bus_a.overflow},
                  {18'd0, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eldq, vecs[i].elow, vecs[i].eovf});
        end

        // level-strobe instance: ten held cycles give 8 pushes and 2 rejections
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus_b.data_stb = 1'b1;
            bus_b.data_in  = DW'(20 + k);
            #1;
            if (!bus_b.ldq) rej++;
            @(posedge clk);
            #1;
            check($sformatf("lvl_b%0d", k), {28'd0, bus_b.level}, (k < 8) ? k : 8);
        end
        @(negedge clk);
        bus_b.data_stb = 1'b0;
        check("rej_b", rej, 2);
        check("ovf_b", {31'd0, bus_b.overflow}, 32'd1);
        check("head_b", {26'd0, bus_b.out_data}, 32'd21);

        // asynchronous reset between edges
        bus_a.out_ready = 1'b0;
        bus_a.data_stb  = 1'b1;
        bus_a.data_in   = 6'd5;
        @(posedge clk);
        #1;
        check("pre_rst", {25'd0, bus_a.out_valid, bus_a.out_data}, {25'd0, 1'b1, 6'd5});
        bus_a.data_stb = 1'b0;
        #2;
        rst_an = 1'b0;
        #1;
        check("async_rst", {26'd0, bus_a.out_valid, bus_a.level, bus_a.ldq}, {26'd0, 1'b0, 4'd0, 1'b1});
        check("async_rst_b", {27'd0, bus_b.level, bus_b.overflow}, 32'd0);
        // strobe already high at reset release must not push
        @(negedge clk);
        bus_a.data_stb = 1'b1;
        bus_a.data_in  = 6'd9;
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;
        check("stb_at_release", {27'd0, bus_a.out_valid, bus_a.level}, 32'd0);
        @(negedge clk);
        bus_a.data_stb = 1'b0;
        @(negedge clk);
        bus_a.data_stb = 1'b1;
        @(posedge clk);
        #1;
        check("edge_after_release", {23'd0, bus_a.out_valid, bus_a.level, bus_a.out_data},
              {23'd0, 1'b1, 4'd1, 6'd9});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/allophone_fifo.md
# allophone_fifo

Parametrised allophone command queue sitting between the host strobe interface (`data_in`/`data_stb`/`ldq`) and the speech sequencer.
It replaces the single-entry load register with a DEPTH-entry first-word-fall-through FIFO.
It adds a selectable strobe mode, fill-level reporting, a low-water prefetch flag, a sticky overflow flag and a synchronous flush.
The host can therefore queue whole words while the sequencer consumes allophones at its own pace.

## Interface
- `DATA_W`, 6: allophone code width.
- `DEPTH`, 8: number of entries; power of two, 2..64.
- `LOW_TH`, 2: `low_water` asserts when level ≤ LOW_TH; range 0..DEPTH-1.
- `STB_EDGE`, 1: 1 = push on rising edge of `data_stb`; 0 = push on every cycle `data_stb` is high.
- `clk` in 1: single system clock, all state on rising edge.
- `rst_an` in 1: asynchronous, active-low reset.
- `data_in` in DATA_W: allophone code from host.
- `data_stb` in 1: host load strobe.
- `ldq` out 1: load request; high when a push will be accepted (level < DEPTH).
- `flush` in 1: synchronous clear of queue and overflow flag.
- `out_data` out DATA_W: head entry; valid only while `out_valid`.
- `out_valid` out 1: queue not empty.
- `out_ready` in 1: sequencer consumes head when high together with `out_valid`.
- `level` out clog2(DEPTH+1): current number of entries.
- `low_water` out 1: level ≤ LOW_TH.
- `overflow` out 1: sticky; a strobe arrived while `ldq` was low.

## Operation
- State: write pointer, read pointer (clog2(DEPTH) bits, natural wrap), level counter, overflow flag, `stb_d` (previous `data_stb`, STB_EDGE=1 only), storage array.
- Push request: `push_req = data_stb & ~stb_d` (STB_EDGE=1) or `push_req = data_stb` (STB_EDGE=0).
- Push: `push_req & ldq`. `data_in` is written at the write pointer, the write pointer increments and wraps to 0 after DEPTH-1.
- Rejected push: `push_req & ~ldq`. Data is dropped and `overflow` is set. No other state changes.
- Pop: `out_valid & out_ready`. The read pointer increments and wraps.
- Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It never exceeds DEPTH and never goes below 0.
- Full with pop in the same cycle: `ldq` is already low, so the push is rejected and `overflow` is set. Level becomes DEPTH-1.
- Empty with push in the same cycle: no pop, because `out_valid` is low. The push is accepted.
- Flush has priority over push and pop. It zeroes the pointers, level and `overflow`, and `stb_d` keeps tracking. A strobe in the flush cycle is discarded without setting `overflow`.
- `out_data` comes from the storage array indexed by the read pointer. It is combinational from registered state, with no input-to-output combinational path.
- Combinational decodes of `level`: `ldq = (level != DEPTH)`, `out_valid = (level != 0)`, `low_water = (level <= LOW_TH)`.
- Storage contents are not reset. All other state resets asynchronously.

## Timing
- Reset values: `ldq`=1, `out_valid`=0, `level`=0, `low_water`=1, `overflow`=0, `out_data`=don't-care. `stb_d` resets to 1, so a strobe already high when reset releases is not taken as an edge.
- Push latency: a push accepted at edge N gives `out_valid`=1 and `out_data` equal to the pushed value after edge N. Fall-through is one cycle.
- Pop: the head advances after the consuming edge. The next entry appears the same cycle.
- `ldq` falls right after the edge that makes level equal DEPTH, and rises right after the first pop from full.
- STB_EDGE=1: a strobe held high for k cycles pushes once. A new push needs `data_stb` to return low for at least one sampled cycle.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Queued entries are lost.

## Structure
- Shared package `speech256_pkg`:
  - `ALLO_W` = 6 (default for DATA_W);
  - pause allophone codes (PA1..PA5 = 0..4) for bench use;
  - a `clog2` function.
- One sub-module, `allophone_fifo_mem`:
  - DEPTH×DATA_W register array;
  - one write port (we, waddr, wdata) and one asynchronous read port;
  - no reset on the array.
- Top holds the pointers, counter, strobe edge detector and flags.

## Test plan
- Reset, then push codes 6, 12, 0x3F as three single-cycle strobes with `out_ready`=0:
  - `level`=3 and `low_water`=0 (LOW_TH=2);
  - `out_data`=6;
  - popping 3 times yields 6, 12, 0x3F, then `out_valid`=0.
- Fill DEPTH=8 entries, then strobe a 9th:
  - `ldq`=0 and `overflow`=1;
  - `level` stays 8 and the 9th value never appears at the output.
- At full, assert strobe and `out_ready` in the same cycle:
  - pop accepted and push rejected;
  - `level`=7 and `overflow`=1.
- STB_EDGE=1 with `data_stb` held high for 10 cycles: exactly 1 push. With STB_EDGE=0, the same stimulus gives 8 pushes and 2 overflows.
- Run 20 push/pop pairs with continuous `out_ready`:
  - pointers wrap twice and output order is preserved;
  - `level` toggles 0/1 throughout.
- Cover flush and reset mid-operation:
  - flush with 5 entries and `overflow`=1 gives `level`=0, `overflow`=0, `ldq`=1 next cycle;
  - deasserting `rst_an` between edges drops `out_valid` immediately.
